// File: rtl/hcsr04_medidor_pkg.sv
// hcsr04_medidor shared types: state codes, BCD width, timing defaults.
// Saturating BCD increment used by the counter and the rounding path.
package hcsr04_medidor_pkg;

  localparam int BCD_W = 12;
  localparam logic [BCD_W-1:0] MEDIDA_TIMEOUT = 12'h999;
  localparam logic [3:0] DB_INVALIDO = 4'b1111;

  localparam int CLKS_TRIGGER_DEF = 500;
  localparam int CLKS_PER_CM_DEF = 2941;
  localparam int CLKS_TIMEOUT_DEF = 1_500_000;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARA     = 4'b0001,
    TRIGGER     = 4'b0010,
    ESPERA_ECHO = 4'b0011,
    CONTA       = 4'b0100,
    ARMAZENA    = 4'b0101,
    FIM         = 4'b0110
  } estado_t;

  function automatic logic [BCD_W-1:0] bcd_inc_sat(
    input logic [BCD_W-1:0] v
  );
    logic [BCD_W-1:0] r;
    r = v;
    if (v != MEDIDA_TIMEOUT) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4] = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hcsr04_medidor_if.sv
// Request/result bundle between the control unit and the HC-SR04 meter.
// master = control unit, slave = meter.
interface hcsr04_medidor_if;
  import hcsr04_medidor_pkg::*;

  logic             medir;
  logic             pronto;
  logic             erro;
  logic [BCD_W-1:0] medida;

  modport master (
    output medir,
    input  pronto,
    input  erro,
    input  medida
  );

  modport slave (
    input  medir,
    output pronto,
    output erro,
    output medida
  );

endinterface

// File: rtl/hcsr04_contador_cm.sv
// Echo-width prescaler (ticks per cm) feeding a saturating 3-digit BCD
// counter; the residual tick count is exported for rounding.
module hcsr04_contador_cm
  import hcsr04_medidor_pkg::*;
#(
  parameter int CLKS_PER_CM = CLKS_PER_CM_DEF,
  localparam int RW = $clog2(CLKS_PER_CM + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             conta,
  output logic [BCD_W-1:0] bcd,
  output logic [RW-1:0]    resto
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resto <= '0;
      bcd <= '0;
    end else if (zera) begin
      resto <= '0;
      bcd <= '0;
    end else if (conta) begin
      if (resto == RW'(CLKS_PER_CM - 1)) begin
        resto <= '0;
        bcd <= bcd_inc_sat(bcd);
      end else begin
        resto <= resto + RW'(1);
      end
    end
  end

endmodule

// File: rtl/hcsr04_medidor.sv
// HC-SR04 trigger/echo meter producing a 3-digit BCD distance in cm.
// Optional HCSR04_ARREDONDA_EN rounds half-centimetre residuals up.
module hcsr04_medidor
  import hcsr04_medidor_pkg::*;
#(
  parameter int CLKS_TRIGGER = CLKS_TRIGGER_DEF,
  parameter int CLKS_PER_CM = CLKS_PER_CM_DEF,
  parameter int CLKS_TIMEOUT = CLKS_TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 echo,
  output logic                 trigger,
  output logic [3:0]           db_estado,
  hcsr04_medidor_if.slave      bus
);

  localparam int TGW = $clog2(CLKS_TRIGGER + 1);
  localparam int TOW = $clog2(CLKS_TIMEOUT + 1);
  localparam int RW = $clog2(CLKS_PER_CM + 1);

`ifdef HCSR04_ARREDONDA_EN
  localparam bit ARREDONDA = 1'b1;
`else
  localparam bit ARREDONDA = 1'b0;
`endif

  estado_t estado, prox;

  logic echo_s1, echo_s2, echo_s3;
  logic sobe, desce;
  logic [TGW-1:0] cnt_trig;
  logic [TOW-1:0] cnt_to;
  logic fim_trig, estourou, tmo;
  logic pronto, erro;
  logic [BCD_W-1:0] medida, bcd, valor;
  logic [RW-1:0] resto;

  assign sobe = echo_s2 & ~echo_s3;
  assign desce = ~echo_s2 & echo_s3;
  assign fim_trig = (cnt_trig == TGW'(CLKS_TRIGGER - 1));
  assign estourou = (cnt_to == TOW'(CLKS_TIMEOUT - 1));

  hcsr04_contador_cm #(
    .CLKS_PER_CM(CLKS_PER_CM)
  ) u_contador (
    .clock(clock),
    .reset(reset),
    .zera(estado == PREPARA),
    .conta(estado == CONTA),
    .bcd(bcd),
    .resto(resto)
  );

  assign valor = (ARREDONDA && resto >= RW'(CLKS_PER_CM / 2))
               ? bcd_inc_sat(bcd) : bcd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else estado <= prox;
  end

  // timeout outranks an echo edge seen in the same cycle
  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL:     if (bus.medir) prox = PREPARA;
      PREPARA:     prox = TRIGGER;
      TRIGGER:     if (fim_trig) prox = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (estourou) prox = ARMAZENA;
        else if (sobe) prox = CONTA;
      end
      CONTA:       if (estourou || desce) prox = ARMAZENA;
      ARMAZENA:    prox = FIM;
      FIM:         prox = INICIAL;
      default:     prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
      trigger <= 1'b0;
      pronto <= 1'b0;
      erro <= 1'b0;
      tmo <= 1'b0;
      medida <= '0;
      cnt_trig <= '0;
      cnt_to <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
      trigger <= (prox == TRIGGER);
      pronto <= (estado == FIM);
      unique case (estado)
        PREPARA: begin
          cnt_trig <= '0;
          cnt_to <= '0;
          tmo <= 1'b0;
          erro <= 1'b0;
        end
        TRIGGER: cnt_trig <= cnt_trig + TGW'(1);
        ESPERA_ECHO, CONTA: begin
          cnt_to <= cnt_to + TOW'(1);
          tmo <= estourou;
        end
        ARMAZENA: begin
          medida <= tmo ? MEDIDA_TIMEOUT : valor;
          if (tmo) erro <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    db_estado = DB_INVALIDO;
    case (estado)
      INICIAL, PREPARA, TRIGGER, ESPERA_ECHO,
      CONTA, ARMAZENA, FIM: db_estado = estado;
      default: db_estado = DB_INVALIDO;
    endcase
  end

  assign bus.pronto = pronto;
  assign bus.erro = erro;
  assign bus.medida = medida;

endmodule

// File: tb/tb_hcsr04_medidor.sv
// Randomized bench for hcsr04_medidor with a cycle-level reference model.
// Honors HCSR04_ARREDONDA_EN the same way the design does.
module tb_hcsr04_medidor;
  import hcsr04_medidor_pkg::*;

  localparam int TRG = 5;
  localparam int CPC = 7;
  localparam int TMO = 8000;

  logic clock = 1'b0;
  logic reset;
  logic echo;
  logic trigger;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  hcsr04_medidor_if bus();

  hcsr04_medidor #(
    .CLKS_TRIGGER(TRG),
    .CLKS_PER_CM(CPC),
    .CLKS_TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .echo(echo),
    .trigger(trigger),
    .db_estado(db_estado),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic confere(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] esp
  );
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, esp);
    end
  endtask

  // echo width in clocks -> BCD centimetres
  function automatic logic [11:0] modelo_cm(input int w);
    int cm;
    logic [11:0] r;
    cm = w / CPC;
`ifdef HCSR04_ARREDONDA_EN
    if ((w % CPC) >= CPC / 2) cm++;
`endif
    if (cm > 999) cm = 999;
    r[11:8] = 4'(cm / 100);
    r[7:4] = 4'((cm / 10) % 10);
    r[3:0] = 4'(cm % 10);
    return r;
  endfunction

  task automatic dispara(input bit eco_cedo);
    int k;
    int n;
    @(negedge clock);
    bus.medir = 1'b1;
    if (eco_cedo) echo = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      bus.medir = 1'b0;
      k++;
    end while (!trigger && k < 8);
    confere("atraso_trigger", k, 2);
    n = 0;
    while (trigger && n < TRG + 8) begin
      @(negedge clock);
      n++;
    end
    confere("largura_trigger", n, TRG);
    confere("estado_espera", db_estado, 4'h3);
  endtask

  // d<0: echo already high before the wait state is entered
  task automatic medicao(input int d, input int w, input int medir_em);
    int k;
    int visto;
    int pulsos;
    int esp_k;
    bit tmo;
    tmo = (d < 0) || (w == 0) || (d + w + 2 >= TMO - 1);
    esp_k = tmo ? TMO + 2 : d + w + 5;
    dispara(d < 0);
    k = 0;
    visto = -1;
    pulsos = 0;
    while (k <= TMO + 10) begin
      if (d >= 0) echo = (k >= d) && (k < d + w);
      bus.medir = (k == medir_em);
      if (bus.pronto) begin
        pulsos++;
        if (visto < 0) visto = k;
      end
      if (visto >= 0 && k >= visto + 3) break;
      @(negedge clock);
      k++;
    end
    echo = 1'b0;
    bus.medir = 1'b0;
    confere($sformatf("pronto_ciclo d=%0d w=%0d", d, w), visto, esp_k);
    confere("pronto_pulsos", pulsos, 1);
    confere("medida", bus.medida, tmo ? 12'h999 : modelo_cm(w));
    confere("erro", bus.erro, 32'(tmo));
    confere("estado_final", db_estado, 0);
  endtask

  task automatic reset_em_conta();
    int p;
    dispara(1'b0);
    repeat (3) @(negedge clock);
    echo = 1'b1;
    repeat (40) @(negedge clock);
    confere("estado_conta", db_estado, 4'h4);
    #2 reset = 1'b1;
    #1;
    confere("rst_trigger", trigger, 0);
    confere("rst_medida", bus.medida, 0);
    confere("rst_pronto", bus.pronto, 0);
    confere("rst_estado", db_estado, 0);
    @(negedge clock);
    reset = 1'b0;
    echo = 1'b0;
    p = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.pronto) p++;
    end
    confere("rst_sem_pronto", p, 0);
  endtask

  initial begin
    reset = 1'b1;
    echo = 1'b0;
    bus.medir = 1'b0;
    repeat (3) @(negedge clock);
    confere("ini_trigger", trigger, 0);
    confere("ini_medida", bus.medida, 0);
    confere("ini_pronto", bus.pronto, 0);
    confere("ini_erro", bus.erro, 0);
    confere("ini_estado", db_estado, 0);
    reset = 1'b0;

    medicao(3, 100 * CPC, -1);
    medicao(2, 23 * CPC + 3, -1);
    medicao(5, 23 * CPC + 2, -1);
    medicao(0, 1, -1);
    repeat (10) begin
      medicao(int'($urandom_range(0, 15)), int'($urandom_range(1, 900)), -1);
    end
    medicao(1, 1000 * CPC + 3, -1);
    medicao(0, 0, -1);
    medicao(4, 57, -1);
    medicao(-1, 0, -1);
    medicao(4, TMO - 3 - 4, -1);
    medicao(4, TMO - 4 - 4, -1);
    medicao(2, 100, 50);
    medicao(6, 321, -1);
    reset_em_conta();
    medicao(1, int'($urandom_range(1, 500)), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
